// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller: source indices,
// request FSM states, bus/vector bases and the vector helper.
package interrupt_pkg;

  localparam logic [12:0] VECTOR_BASE    = 13'h0100;
  localparam logic [11:0] MASK_BASE_ADDR = 12'hF10;

  typedef enum logic [2:0] {
    SRC_CLOCK     = 3'd0,
    SRC_STOPWATCH = 3'd1,
    SRC_INPUT0    = 3'd2,
    SRC_INPUT1    = 3'd3,
    SRC_SERIAL    = 3'd4,
    SRC_PROG      = 3'd5
  } irq_src_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  // Each source owns a two-word vector slot starting one slot above the base.
  function automatic logic [12:0] src_vector(input logic [12:0] base, input int idx);
    return base + 13'(2 * (idx + 1));
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the highest set bit of the pending vector wins.
module irq_priority_encoder #(
  parameter int N    = 6,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    pend,
  output logic [IDXW-1:0] idx,
  output logic            vld
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) idx = IDXW'(i);
    end
  end

  assign vld = |pend;

endmodule

// File: rtl/interrupt_controller.sv
// Masks source factor flags, arbitrates by fixed priority and hands one latched
// request/vector to the core. Define IRQ_STATS_EN to add per-source ack counters.
module interrupt_controller #(
  parameter int          NUM_SOURCES    = 6,
  parameter logic [12:0] VECTOR_BASE    = interrupt_pkg::VECTOR_BASE,
  parameter logic [11:0] MASK_BASE_ADDR = interrupt_pkg::MASK_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_clk_en,
  input  logic [4*NUM_SOURCES-1:0] factor,
  input  logic                     cpu_interrupt_en,
  input  logic [11:0]              bus_addr,
  input  logic                     bus_wr,
  input  logic [3:0]               bus_wdata,
  output logic [3:0]               bus_rdata,
  output logic                     bus_rd_hit,
  output logic                     irq_req,
  output logic [12:0]              irq_vector,
  input  logic                     irq_ack,
  output logic                     wake
`ifdef IRQ_STATS_EN
  ,
  output logic [8*NUM_SOURCES-1:0] irq_count
`endif
);

  import interrupt_pkg::*;

  localparam int IDXW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0][3:0] mask_q, mask_d;
  logic [NUM_SOURCES-1:0]      pend;
  logic [IDXW-1:0]             enc_idx;
  logic                        enc_vld;
  irq_state_e                  state_q, state_d;
  logic [12:0]                 vector_q, vector_d;
  logic                        wake_q, wake_d;
  logic [11:0]                 addr_off;
  logic                        win_hit;

  assign addr_off   = bus_addr - MASK_BASE_ADDR;
  assign win_hit    = addr_off < 12'(NUM_SOURCES);
  assign bus_rd_hit = win_hit;

  always_comb begin
    bus_rdata = '0;
    mask_d    = mask_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (win_hit && addr_off == 12'(i)) begin
        bus_rdata = mask_q[i];
        // The prog timer has a single factor bit, so only mask bit 0 exists.
        if (cpu_clk_en && bus_wr)
          mask_d[i] = (i == NUM_SOURCES - 1) ? {3'b000, bus_wdata[0]} : bus_wdata;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++)
      pend[i] = |(factor[4*i +: 4] & mask_q[i]);
  end

  irq_priority_encoder #(
    .N    (NUM_SOURCES),
    .IDXW (IDXW)
  ) u_prio (
    .pend (pend),
    .idx  (enc_idx),
    .vld  (enc_vld)
  );

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    wake_d   = wake_q;
    if (cpu_clk_en) begin
      wake_d = |pend;
      case (state_q)
        IDLE: begin
          if (enc_vld && cpu_interrupt_en) begin
            vector_d = src_vector(VECTOR_BASE, int'(enc_idx));
            state_d  = REQ;
          end
        end
        // Once raised, the request stays up until acked; cancellation is the core's job.
        REQ:     if (irq_ack) state_d = HOLDOFF;
        HOLDOFF: if (!cpu_interrupt_en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      state_q  <= IDLE;
      vector_q <= '0;
      wake_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      state_q  <= state_d;
      vector_q <= vector_d;
      wake_q   <= wake_d;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_vector = vector_q;
  assign wake       = wake_q;

`ifdef IRQ_STATS_EN
  logic [NUM_SOURCES-1:0][7:0] cnt_q, cnt_d;
  logic                        ack_take;

  assign ack_take = cpu_clk_en && (state_q == REQ) && irq_ack;

  // The latched vector identifies the acknowledged source uniquely.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (ack_take && vector_q == src_vector(VECTOR_BASE, i) && cnt_q[i] != 8'hFF)
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign irq_count = cnt_q;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized and directed bench for interrupt_controller against a behavioural model.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic [23:0] factor = '0;
  logic        cpu_interrupt_en = 1'b0;
  logic [11:0] bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic [3:0]  bus_wdata = '0;
  logic [3:0]  bus_rdata;
  logic        bus_rd_hit;
  logic        irq_req;
  logic [12:0] irq_vector;
  logic        irq_ack = 1'b0;
  logic        wake;
`ifdef IRQ_STATS_EN
  logic [47:0] irq_count;
`endif

  interrupt_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cpu_clk_en       (cpu_clk_en),
    .factor           (factor),
    .cpu_interrupt_en (cpu_interrupt_en),
    .bus_addr         (bus_addr),
    .bus_wr           (bus_wr),
    .bus_wdata        (bus_wdata),
    .bus_rdata        (bus_rdata),
    .bus_rd_hit       (bus_rd_hit),
    .irq_req          (irq_req),
    .irq_vector       (irq_vector),
    .irq_ack          (irq_ack),
    .wake             (wake)
`ifdef IRQ_STATS_EN
    ,
    .irq_count        (irq_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: masks, whether a request is outstanding, whether we are
  // waiting for the core to drop I, the latched vector and the wake flag.
  logic [3:0]  m_mask [6];
  bit          m_req, m_hold, m_wake;
  logic [12:0] m_vec;
  int          m_src;
  int          m_cnt [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_mask[i] = 4'h0;
      m_cnt[i]  = 0;
    end
    m_req = 0; m_hold = 0; m_wake = 0; m_vec = '0; m_src = 0;
  endtask

  function automatic int win_index(input logic [11:0] addr);
    int off;
    off = int'(addr) - 'hF10;
    return (off >= 0 && off < 6) ? off : -1;
  endfunction

  task automatic model_advance();
    logic [5:0] pend;
    int hi, w;
    if (cpu_clk_en) begin
      hi = -1;
      for (int i = 0; i < 6; i++) begin
        pend[i] = ((factor >> (4 * i)) & 24'(m_mask[i])) != 0;
        if (pend[i]) hi = i;
      end
      m_wake = (pend != 0);
      if (m_req) begin
        if (irq_ack) begin
          m_req = 0; m_hold = 1;
          if (m_cnt[m_src] < 255) m_cnt[m_src]++;
        end
      end else if (m_hold) begin
        if (!cpu_interrupt_en) m_hold = 0;
      end else if (hi >= 0 && cpu_interrupt_en) begin
        m_req = 1;
        m_src = hi;
        m_vec = 13'(32'h100 + 2 * (hi + 1));
      end
      w = win_index(bus_addr);
      if (bus_wr && w >= 0) m_mask[w] = (w == 5) ? (bus_wdata & 4'h1) : bus_wdata;
    end
  endtask

  task automatic check_outputs();
    chk("irq_req", 64'(irq_req), 64'(m_req));
    chk("irq_vector", 64'(irq_vector), 64'(m_vec));
    chk("wake", 64'(wake), 64'(m_wake));
`ifdef IRQ_STATS_EN
    for (int i = 0; i < 6; i++) chk("irq_count", 64'(irq_count[8*i +: 8]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic step(input logic en, input logic [23:0] fac, input logic ie,
                      input logic [11:0] addr, input logic wr, input logic [3:0] wd,
                      input logic ack);
    int w;
    @(negedge clk);
    cpu_clk_en = en; factor = fac; cpu_interrupt_en = ie;
    bus_addr = addr; bus_wr = wr; bus_wdata = wd; irq_ack = ack;
    #1;
    w = win_index(addr);
    chk("bus_rd_hit", 64'(bus_rd_hit), 64'(w >= 0));
    chk("bus_rdata", 64'(bus_rdata), (w >= 0) ? 64'(m_mask[w]) : 64'(0));
    model_advance();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr_mask(input logic [11:0] addr, input logic [3:0] d);
    step(1'b1, 24'h0, 1'b0, addr, 1'b1, d, 1'b0);
  endtask

  localparam logic [23:0] F_PROG = 24'h100000;

  initial begin
    model_reset();
    #1;
    chk("rst_irq_req", 64'(irq_req), 64'(0));
    chk("rst_irq_vector", 64'(irq_vector), 64'(0));
    chk("rst_wake", 64'(wake), 64'(0));
    for (int i = 0; i < 6; i++) begin
      bus_addr = 12'hF10 + 12'(i);
      #1;
      chk("rst_mask", 64'(bus_rdata), 64'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Prog timer request, ack, and holdoff until I drops.
    wr_mask(12'hF15, 4'h1);
    step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
    chk("prog_req", 64'(irq_req), 64'(1));
    chk("prog_vec", 64'(irq_vector), 64'(13'h010C));
    step(1, F_PROG, 1, 12'hF15, 0, 0, 1);
    chk("prog_ack", 64'(irq_req), 64'(0));
    step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
    chk("prog_holdoff", 64'(irq_req), 64'(0));
    step(1, 24'h0, 0, 12'hF15, 0, 0, 0);

    // Masked-off source.
    wr_mask(12'hF15, 4'h0);
    step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
    step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
    chk("masked_req", 64'(irq_req), 64'(0));
    chk("masked_wake", 64'(wake), 64'(0));

    // Priority: stopwatch over clock timer, then clock timer on the next pass.
    wr_mask(12'hF10, 4'hF);
    wr_mask(12'hF11, 4'hF);
    step(1, 24'h000022, 1, 12'hF10, 0, 0, 0);
    chk("prio_vec_sw", 64'(irq_vector), 64'(13'h0104));
    step(1, 24'h000022, 1, 12'hF10, 0, 0, 1);
    step(1, 24'h000022, 0, 12'hF10, 0, 0, 0);
    step(1, 24'h000002, 1, 12'hF10, 0, 0, 0);
    chk("prio_vec_clk", 64'(irq_vector), 64'(13'h0102));
    step(1, 24'h000002, 1, 12'hF10, 0, 0, 1);
    step(1, 24'h000002, 0, 12'hF10, 0, 0, 0);

    // I flag low: wake without request, then request once I rises.
    step(1, 24'h000002, 0, 12'hF10, 0, 0, 0);
    step(1, 24'h000002, 0, 12'hF10, 0, 0, 0);
    chk("iclr_req", 64'(irq_req), 64'(0));
    chk("iclr_wake", 64'(wake), 64'(1));
    step(1, 24'h000002, 1, 12'hF10, 0, 0, 0);
    chk("iset_req", 64'(irq_req), 64'(1));
    step(1, 24'h0, 1, 12'hF10, 0, 0, 1);
    step(1, 24'h0, 0, 12'hF10, 0, 0, 0);

    // Mask readback and out-of-window read.
    wr_mask(12'hF15, 4'hA);
    wr_mask(12'hF12, 4'h5);
    step(1, 24'h0, 0, 12'hF15, 0, 0, 0);
    chk("rb_f15", 64'(bus_rdata), 64'(0));
    step(1, 24'h0, 0, 12'hF12, 0, 0, 0);
    chk("rb_f12", 64'(bus_rdata), 64'(5));
    step(1, 24'h0, 0, 12'hF20, 0, 0, 0);
    chk("rb_f20_hit", 64'(bus_rd_hit), 64'(0));

    // Asynchronous reset while a request is outstanding.
    wr_mask(12'hF15, 4'h1);
    step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
    chk("pre_rst_req", 64'(irq_req), 64'(1));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req", 64'(irq_req), 64'(0));
    chk("arst_vec", 64'(irq_vector), 64'(0));
    bus_addr = 12'hF15;
    #1;
    chk("arst_mask", 64'(bus_rdata), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [23:0] fac;
      logic [11:0] addr;
      for (int i = 0; i < 6; i++)
        fac[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      addr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'hF0E + 12'($urandom_range(0, 9));
      step($urandom_range(0, 3) != 0, fac, $urandom_range(0, 2) != 0, addr,
           $urandom_range(0, 5) == 0, 4'($urandom), $urandom_range(0, 2) == 0);
    end

`ifdef IRQ_STATS_EN
    wr_mask(12'hF15, 4'h1);
    step(1, 24'h0, 0, 12'hF15, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      step(1, F_PROG, 1, 12'hF15, 0, 0, 0);
      step(1, F_PROG, 1, 12'hF15, 0, 0, 1);
      step(1, F_PROG, 0, 12'hF15, 0, 0, 0);
    end
    chk("prog_count_sat", 64'(irq_count[47:40]), 64'(8'hFF));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
